// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC, bubble encoding,
// fetch FSM states and the {pc, instr} FIFO entry layout.
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    // Same encoding the IF/ID flush loads, so an empty FIFO looks like a flushed slot.
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    typedef enum logic {
        ST_FETCH   = 1'b0,
        ST_DISCARD = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage signal bundle: hazard/redirect inputs, instruction-memory req/ack bus
// and the IF/ID-facing outputs. master = fetch unit, slave = its environment.
interface if_fetch_unit_if;

    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] nowpc_o;
    logic [31:0] instruction_o;
    logic        valid_o;
    logic        ifid_write_o;
    logic        flush_o;

    modport master (
        input  stall_i, branch_taken_i, branch_target_i, imem_ack_i, imem_rdata_i,
        output imem_req_o, imem_addr_o, nowpc_o, instruction_o, valid_o,
               ifid_write_o, flush_o
    );

    modport slave (
        output stall_i, branch_taken_i, branch_target_i, imem_ack_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o, nowpc_o, instruction_o, valid_o,
               ifid_write_o, flush_o
    );

endinterface

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Synchronous {pc,instr} FIFO; head is visible combinationally, push lands next cycle.
// Clear beats push/pop; pushes while full and pops while empty are ignored.
module fetch_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_clear,
    input  fetch_entry_t                 i_dat,
    output fetch_entry_t                 o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk_i) begin
        if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_dat;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns PC, one outstanding req/ack fetch, DEPTH-entry buffer feeding IF/ID.
// Ack to valid_o is 1 cycle; a full buffer drops req; redirect flushes and discards a stale fetch.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    if_fetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e  r_state;
    fetch_state_e  w_state_nxt;
    logic [31:0]   r_pc;
    logic [31:0]   w_pc_nxt;
    logic [31:0]   r_stale_addr;
    logic [31:0]   w_stale_nxt;
    logic          w_req;
    logic          w_ack;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_dat;

    // req never falls without an ack: the buffer only grows through an ack, and a
    // redirect that would move the address parks the old one in DISCARD instead.
    assign w_req      = !rst_i && ((r_state == ST_DISCARD) || !w_full);
    assign w_ack      = w_req && bus.imem_ack_i;
    assign w_push     = (r_state == ST_FETCH) && w_ack && !bus.branch_taken_i;
    assign w_pop      = !w_empty && !bus.stall_i && !bus.branch_taken_i;
    assign w_push_dat = {r_pc, bus.imem_rdata_i};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (bus.branch_taken_i),
        .i_dat   (w_push_dat),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_stale_nxt = r_stale_addr;
        if (bus.branch_taken_i) begin
            w_pc_nxt = word_align(bus.branch_target_i);
            if (w_req && !w_ack) begin
                w_state_nxt = ST_DISCARD;
                // A redirect during DISCARD must keep tracking the original stale address.
                if (r_state == ST_FETCH) w_stale_nxt = r_pc;
            end else begin
                w_state_nxt = ST_FETCH;
            end
        end else begin
            if (w_push) w_pc_nxt = r_pc + 32'd4;
            if ((r_state == ST_DISCARD) && w_ack) w_state_nxt = ST_FETCH;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_stale_addr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_stale_addr <= w_stale_nxt;
        end
    end

    assign bus.imem_req_o    = w_req;
    assign bus.imem_addr_o   = (r_state == ST_DISCARD) ? r_stale_addr : r_pc;
    assign bus.valid_o       = !w_empty;
    assign bus.instruction_o = w_empty ? NOP_INSTR : w_head.instr;
    assign bus.nowpc_o       = w_empty ? 32'h0 : w_head.pc;
    assign bus.ifid_write_o  = !bus.stall_i;
    assign bus.flush_o       = bus.branch_taken_i;

    a_push_not_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_push && (w_count == CW'(DEPTH))));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: vector table, corner sequences and a random run against a
// program-order stream model with a variable-latency instruction memory.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_fetch_unit_if bus_if();

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    int total = 0;
    int bad   = 0;

    // Memory model state
    logic        m_busy;
    logic [31:0] m_addr;
    int          m_left;
    int          lat_fixed;
    logic [31:0] slow_addr;
    logic        spur_ack;

    // Stream model: next PC IF/ID must receive, in program order
    logic [31:0] exp_pc;
    int          gap, max_gap, npops;

    // Values sampled at the negedge of the last cycle
    logic        s_req, s_valid, s_flush, s_wr, s_ack;
    logic [31:0] s_addr, s_nowpc, s_instr;

    typedef struct {
        logic        stall;
        logic        br;
        logic        spur;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] nowpc;
    } vec_t;
    vec_t vecs [17];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic st, input logic br, input logic sp,
                        input logic [31:0] tg, input logic rq, input logic [31:0] ad,
                        input logic vl, input logic [31:0] pc);
        vecs[i].stall = st; vecs[i].br = br; vecs[i].spur = sp; vecs[i].tgt = tg;
        vecs[i].req = rq; vecs[i].addr = ad; vecs[i].valid = vl; vecs[i].nowpc = pc;
    endtask

    task automatic drive_mem();
        bus_if.imem_ack_i   = 1'b0;
        bus_if.imem_rdata_i = 32'hDEAD_BEEF;
        if (rst) begin
            m_busy = 1'b0;
        end else begin
            if (m_busy) begin
                chk1("req_held_until_ack", bus_if.imem_req_o, 1'b1);
                chk("addr_stable", bus_if.imem_addr_o, m_addr);
            end
            if (bus_if.imem_req_o) begin
                if (!m_busy) begin
                    m_busy = 1'b1;
                    m_addr = bus_if.imem_addr_o;
                    if (m_addr == slow_addr)  m_left = 3;
                    else if (lat_fixed >= 0)  m_left = lat_fixed;
                    else                      m_left = int'($urandom_range(0, 3));
                end
                if (m_left == 0) begin
                    bus_if.imem_ack_i   = 1'b1;
                    bus_if.imem_rdata_i = instr_of(m_addr);
                end
            end else begin
                bus_if.imem_ack_i   = spur_ack;
                bus_if.imem_rdata_i = 32'hBAD0_0000;
            end
        end
    endtask

    task automatic model_check();
        logic pop;
        pop = s_valid && !bus_if.stall_i && !bus_if.branch_taken_i;
        chk1("flush", s_flush, bus_if.branch_taken_i);
        chk1("ifid_write", s_wr, !bus_if.stall_i);
        if (!s_valid) begin
            chk("bubble_pc", s_nowpc, 32'h0);
            chk("bubble_instr", s_instr, NOP_INSTR);
        end else if (pop) begin
            chk("stream_pc", s_nowpc, exp_pc);
            chk("stream_instr", s_instr, instr_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
            npops++;
        end
        if (bus_if.branch_taken_i) exp_pc = bus_if.branch_target_i & 32'hFFFF_FFFC;
        if (pop || bus_if.branch_taken_i) gap = 0;
        else if (!bus_if.stall_i) gap++;
        if (gap > max_gap) max_gap = gap;
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic tick();
        #1;
        drive_mem();
        @(negedge clk);
        s_req   = bus_if.imem_req_o;
        s_addr  = bus_if.imem_addr_o;
        s_valid = bus_if.valid_o;
        s_nowpc = bus_if.nowpc_o;
        s_instr = bus_if.instruction_o;
        s_flush = bus_if.flush_o;
        s_wr    = bus_if.ifid_write_o;
        s_ack   = bus_if.imem_ack_i && bus_if.imem_req_o;
        if (!rst) model_check();
        @(posedge clk);
        #1;
        if (rst || s_ack) m_busy = 1'b0;
        else if (m_busy && m_left > 0) m_left--;
        bus_if.imem_ack_i = 1'b0;
    endtask

    task automatic idle_inputs();
        bus_if.stall_i         = 1'b0;
        bus_if.branch_taken_i  = 1'b0;
        bus_if.branch_target_i = 32'h0;
        spur_ack               = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        bus_if.imem_ack_i = 1'b0;
        m_busy = 1'b0;
        exp_pc = 32'h0;
        gap    = 0;
        #1;
        chk1("rst_req", bus_if.imem_req_o, 1'b0);
        chk1("rst_valid", bus_if.valid_o, 1'b0);
        chk("rst_nowpc", bus_if.nowpc_o, 32'h0);
        chk("rst_instr", bus_if.instruction_o, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1;
        idle_inputs();
        bus_if.imem_ack_i   = 1'b0;
        bus_if.imem_rdata_i = 32'h0;
        lat_fixed = 0;
        slow_addr = 32'h1;
        max_gap   = 0;
        npops     = 0;
        m_left    = 0;
        m_addr    = 32'h0;

        //        st br sp tgt          req addr         vl nowpc
        setv( 0, 0, 0, 0, 32'h0,        1, 32'h000,      0, 32'h000);
        setv( 1, 0, 0, 0, 32'h0,        1, 32'h004,      1, 32'h000);
        setv( 2, 0, 0, 0, 32'h0,        1, 32'h008,      1, 32'h004);
        setv( 3, 1, 0, 0, 32'h0,        1, 32'h00C,      1, 32'h008);
        setv( 4, 1, 0, 1, 32'h0,        0, 32'h010,      1, 32'h008);
        setv( 5, 1, 0, 0, 32'h0,        0, 32'h010,      1, 32'h008);
        setv( 6, 0, 0, 0, 32'h0,        0, 32'h010,      1, 32'h008);
        setv( 7, 0, 0, 0, 32'h0,        1, 32'h010,      1, 32'h00C);
        setv( 8, 0, 0, 0, 32'h0,        1, 32'h014,      1, 32'h010);
        setv( 9, 0, 1, 0, 32'h103,      1, 32'h018,      1, 32'h014);
        setv(10, 0, 0, 0, 32'h0,        1, 32'h100,      0, 32'h000);
        setv(11, 0, 0, 0, 32'h0,        1, 32'h104,      1, 32'h100);
        setv(12, 1, 0, 0, 32'h0,        1, 32'h108,      1, 32'h104);
        setv(13, 1, 0, 1, 32'h0,        0, 32'h10C,      1, 32'h104);
        setv(14, 1, 1, 0, 32'h200,      0, 32'h10C,      1, 32'h104);
        setv(15, 0, 0, 0, 32'h0,        1, 32'h200,      0, 32'h000);
        setv(16, 0, 0, 0, 32'h0,        1, 32'h204,      1, 32'h200);

        @(posedge clk);
        #1;
        do_reset();

        // Vector table: streaming, stall fill, spurious ack, redirects
        for (int i = 0; i < 17; i++) begin
            bus_if.stall_i         = vecs[i].stall;
            bus_if.branch_taken_i  = vecs[i].br;
            bus_if.branch_target_i = vecs[i].tgt;
            spur_ack               = vecs[i].spur;
            tick();
            chk1($sformatf("v%0d.req", i), s_req, vecs[i].req);
            chk($sformatf("v%0d.addr", i), s_addr, vecs[i].addr);
            chk1($sformatf("v%0d.valid", i), s_valid, vecs[i].valid);
            chk($sformatf("v%0d.nowpc", i), s_nowpc, vecs[i].nowpc);
            chk($sformatf("v%0d.instr", i), s_instr,
                vecs[i].valid ? instr_of(vecs[i].nowpc) : NOP_INSTR);
        end
        idle_inputs();

        // Redirect while the 0x10 fetch waits three cycles for its ack
        do_reset();
        slow_addr = 32'h10;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (s_req && s_addr == 32'h10) found = 1'b1;
        end
        chk1("seqA_reach_0x10", found, 1'b1);
        bus_if.branch_taken_i  = 1'b1;
        bus_if.branch_target_i = 32'h100;
        tick();
        chk1("seqA_flush", s_flush, 1'b1);
        idle_inputs();
        tick();
        chk1("seqA_flush_one_cycle", s_flush, 1'b0);
        chk("seqA_addr_held1", s_addr, 32'h10);
        chk1("seqA_empty1", s_valid, 1'b0);
        tick();
        chk("seqA_addr_held2", s_addr, 32'h10);
        chk1("seqA_stale_ack", s_ack, 1'b1);
        chk1("seqA_empty2", s_valid, 1'b0);
        tick();
        chk1("seqA_new_req", s_req, 1'b1);
        chk("seqA_new_addr", s_addr, 32'h100);
        tick();
        chk("seqA_first_out", s_nowpc, 32'h100);
        slow_addr = 32'h1;

        // PC wrap through 0xFFFF_FFFC
        do_reset();
        bus_if.branch_taken_i  = 1'b1;
        bus_if.branch_target_i = 32'hFFFF_FFF8;
        tick();
        idle_inputs();
        tick();
        chk("wrap_addr_f8", s_addr, 32'hFFFF_FFF8);
        tick();
        chk("wrap_addr_fc", s_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr_0", s_addr, 32'h0);
        chk("wrap_out_fc", s_nowpc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_out_0", s_nowpc, 32'h0);

        // Reset asserted while a fetch is in flight
        do_reset();
        lat_fixed = 3;
        tick();
        tick();
        chk1("rstmid_pending", m_busy, 1'b1);
        do_reset();
        lat_fixed = 0;
        tick();
        chk1("rstmid_req", s_req, 1'b1);
        chk("rstmid_addr", s_addr, 32'h0);
        tick();
        chk("rstmid_out", s_nowpc, 32'h0);

        // Random run against the stream model
        lat_fixed = -1;
        do_reset();
        npops   = 0;
        max_gap = 0;
        for (int c = 0; c < 3000; c++) begin
            bus_if.stall_i        = ($urandom_range(0, 9) < 3);
            bus_if.branch_taken_i = ($urandom_range(0, 99) < 8);
            bus_if.branch_target_i = ($urandom_range(0, 3) == 0)
                ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            tick();
        end
        idle_inputs();
        chk1("rand_liveness", (max_gap <= 12), 1'b1);
        chk1("rand_progress", (npops > 200), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake with variable latency.
- Buffers returned instructions in a small FIFO and drives instruction/nowpc, write-enable and flush into IF/ID.
- Handles stall from the hazard unit and branch redirect from EX, including discarding a stale in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DEPTH, 2, fetch FIFO entries (power of two, >=2)

Ports:
clk_i  in  1  clock, all state updates on posedge
rst_i  in  1  asynchronous active-high reset
stall_i  in  1  hazard unit: hold IF/ID, do not pop FIFO
branch_taken_i  in  1  redirect request from EX (single-cycle pulse)
branch_target_i  in  32  redirect PC; bits [1:0] ignored, forced to 0
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch byte address, word aligned
imem_ack_i  in  1  fetch complete; imem_rdata_i valid this cycle
imem_rdata_i  in  32  fetched instruction
nowpc_o  out  32  PC of the FIFO head, to IF/ID nowpc input
instruction_o  out  32  FIFO head instruction, to IF/ID instruction input
valid_o  out  1  FIFO non-empty
ifid_write_o  out  1  IF/ID write enable
flush_o  out  1  IF/ID flush

Behaviour:
- Reset, asynchronous:
  - pc=RESET_PC, FIFO empty (count=0), state=FETCH, stale_addr=0.
  - imem_req_o=0 while rst_i is high; valid_o=0, instruction_o=0, nowpc_o=0.
  - A fetch in flight when reset asserts is abandoned; instruction memory is reset alongside this block.
- States:
  - FETCH: imem_req_o = (count<DEPTH); imem_addr_o = pc.
  - DISCARD: imem_req_o=1; imem_addr_o = stale_addr. Waits for the ack of a request made obsolete by a redirect.
- Bus rule: once imem_req_o is asserted, req and addr stay stable until the cycle imem_ack_i=1. At most one request is outstanding. ack with req low is ignored.
- FETCH, ack without redirect: push {pc, imem_rdata_i}; pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0). Back-to-back fetch is allowed, so req may stay high the next cycle.
- Pop: when valid_o & !stall_i & !branch_taken_i. Push and pop in the same cycle leave count unchanged.
- Output mux:
  - FIFO empty: instruction_o=0 and nowpc_o=0, i.e. a bubble.
  - ifid_write_o = !stall_i, so an empty FIFO writes a bubble into IF/ID.
  - instruction_o and nowpc_o are combinational from the FIFO head register; no added latency.
- Redirect (branch_taken_i=1), highest priority, overrides stall_i:
  - flush_o=1 (combinational); FIFO cleared; pc<={branch_target_i[31:2],2'b00}.
  - If req is high and ack is low this cycle: stale_addr<=imem_addr_o; next state DISCARD.
  - If req and ack are both high: the returned data is dropped; next state FETCH.
  - If req is low (FIFO full): next state FETCH.
- DISCARD:
  - On ack, the data is dropped and the state goes to FETCH; the new pc is requested the next cycle.
  - A redirect while in DISCARD updates pc to the new target, keeps stale_addr and stays in DISCARD, or goes to FETCH if ack arrives that cycle.
- Latency: redirect to first new request is 1 cycle when no fetch is stale; otherwise 1 cycle after the stale ack. Ack to valid_o is 1 cycle.
- Boundaries:
  - FIFO full blocks new requests but never blocks an outstanding ack, because count+outstanding <= DEPTH by construction.
  - Assertion: push with count==DEPTH is an error.

Decomposition:
- Shared pipeline package:
  - RESET_PC default.
  - NOP_INSTR=32'h0 bubble constant, matching what the IF/ID flush loads.
  - Fetch state enum {FETCH, DISCARD}.
- Natural sub-module: fetch_fifo. Synchronous FIFO of {pc,instr} entries, DEPTH-parameterized, with push, pop and clear (clear has priority), and count/full/empty outputs.

Test Plan:
- Reset, ack in 1 cycle, no stall: requests at 0x0, 0x4, 0x8; IF/ID sees instr@0x0 with nowpc 0x0, then 0x4, 0x8 on consecutive cycles, ifid_write_o=1.
- stall_i held 5 cycles with ack every cycle: FIFO fills to 2, imem_req_o drops, head stays at the same PC. After release, pops continue in order with no lost or duplicated PC.
- Redirect to 0x100 while a request at 0x10 is waiting for ack (ack delayed 3 cycles):
  - flush_o=1 for 1 cycle; FIFO empties.
  - imem_addr_o stays 0x10 until ack; that data is never output.
  - Next request is 0x100.
- Redirect coincident with ack of 0xC: the 0xC data is dropped and the next request is 0x100. Also branch_target_i=0x103 -> pc 0x100.
- Redirect coincident with stall_i=1 and a full FIFO: flush_o=1, FIFO cleared, next request is the target.
- PC 0xFFFF_FFFC fetched, then wrap: next request is 0x0. rst_i asserted mid-fetch: req drops the same cycle and resumes at RESET_PC after deassert.
